// File: rtl/regfile_bypass_sb.sv
// regfile_bypass_sb: parametrised register file, two combinational read ports,
// two write ports (A wins on collision), same-cycle bypass, busy scoreboard.
module regfile_bypass_sb #(
   parameter int unsigned WORD_SIZE = 16,
   parameter int unsigned ADDR_W    = 2,
   parameter bit          BYPASS_EN = 1'b1,
   parameter bit          ZERO_REG  = 1'b0
) (
   input  logic                   clk,
   input  logic                   reset_n,
   input  logic [ADDR_W-1:0]      readReg1,
   input  logic [ADDR_W-1:0]      readReg2,
   output logic [WORD_SIZE-1:0]   readData1,
   output logic [WORD_SIZE-1:0]   readData2,
   output logic                   readBusy1,
   output logic                   readBusy2,
   input  logic                   wrEnA,
   input  logic [ADDR_W-1:0]      wrRegA,
   input  logic [WORD_SIZE-1:0]   wrDataA,
   input  logic                   wrEnB,
   input  logic [ADDR_W-1:0]      wrRegB,
   input  logic [WORD_SIZE-1:0]   wrDataB,
   input  logic                   rsvEn,
   input  logic [ADDR_W-1:0]      rsvReg,
   output logic [(1<<ADDR_W)-1:0] busyVec,
   output logic                   wrConflict
);

   localparam int unsigned NUM_REGS = 1 << ADDR_W;

   logic [WORD_SIZE-1:0] regs_q [NUM_REGS];
   logic [WORD_SIZE-1:0] regs_d [NUM_REGS];
   logic [NUM_REGS-1:0]  busy_q;
   logic [NUM_REGS-1:0]  busy_d;
   logic                 conflict_q;
   logic                 conflict_d;

   logic [ADDR_W-1:0]    raddr [2];
   logic [WORD_SIZE-1:0] rdata [2];
   logic                 rbusy [2];

   assign raddr[0]   = readReg1;
   assign raddr[1]   = readReg2;
   assign readData1  = rdata[0];
   assign readData2  = rdata[1];
   assign readBusy1  = rbusy[0];
   assign readBusy2  = rbusy[1];
   assign busyVec    = busy_q;
   assign wrConflict = conflict_q;

   // Next state: B then A so A overrides on collision; reserve beats release
   always_comb begin
      regs_d     = regs_q;
      busy_d     = busy_q;
      conflict_d = wrEnA && wrEnB && (wrRegA == wrRegB);
      for (int i = 0; i < NUM_REGS; i++) begin
         if (wrEnB && (wrRegB == ADDR_W'(i))) begin
            regs_d[i] = wrDataB;
         end
         if (wrEnA && (wrRegA == ADDR_W'(i))) begin
            regs_d[i] = wrDataA;
         end
         if (rsvEn && (rsvReg == ADDR_W'(i))) begin
            busy_d[i] = 1'b1;
         end else if ((wrEnA && (wrRegA == ADDR_W'(i))) ||
                      (wrEnB && (wrRegB == ADDR_W'(i)))) begin
            busy_d[i] = 1'b0;
         end
      end
      if (ZERO_REG) begin
         regs_d[0] = '0;
         busy_d[0] = 1'b0;
      end
   end

   // Read ports: A bypass over B bypass over stored; reset and R0 force zero
   always_comb begin
      for (int p = 0; p < 2; p++) begin
         rdata[p] = regs_q[raddr[p]];
         rbusy[p] = busy_q[raddr[p]];
         if (BYPASS_EN && wrEnB && (wrRegB == raddr[p])) begin
            rdata[p] = wrDataB;
         end
         if (BYPASS_EN && wrEnA && (wrRegA == raddr[p])) begin
            rdata[p] = wrDataA;
         end
         if (!reset_n || (ZERO_REG && (raddr[p] == '0))) begin
            rdata[p] = '0;
            rbusy[p] = 1'b0;
         end
      end
   end

   // State registers; reset drops contents, reservations and the flag
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         for (int i = 0; i < NUM_REGS; i++) begin
            regs_q[i] <= '0;
         end
         busy_q     <= '0;
         conflict_q <= 1'b0;
      end else begin
         regs_q     <= regs_d;
         busy_q     <= busy_d;
         conflict_q <= conflict_d;
      end
   end

endmodule

// File: tb/tb_regfile_bypass_sb.sv
// tb_regfile_bypass_sb: directed stimulus on three parameterisations,
// expectations queued and compared by a negedge monitor.
module tb_regfile_bypass_sb;

   logic        clk;
   logic        rst_n;
   logic [2:0]  rr1, rr2, wra, wrb, rsv;
   logic [31:0] wda, wdb;
   logic        wea, web, rsve;

   logic [15:0] o0_rd1, o0_rd2, o1_rd1, o1_rd2;
   logic        o0_b1, o0_b2, o1_b1, o1_b2, o0_cf, o1_cf;
   logic [3:0]  o0_bv, o1_bv;
   logic [31:0] o2_rd1, o2_rd2;
   logic        o2_b1, o2_b2, o2_cf;
   logic [7:0]  o2_bv;

   regfile_bypass_sb u0 (
      .clk(clk), .reset_n(rst_n),
      .readReg1(rr1[1:0]), .readReg2(rr2[1:0]),
      .readData1(o0_rd1), .readData2(o0_rd2),
      .readBusy1(o0_b1), .readBusy2(o0_b2),
      .wrEnA(wea), .wrRegA(wra[1:0]), .wrDataA(wda[15:0]),
      .wrEnB(web), .wrRegB(wrb[1:0]), .wrDataB(wdb[15:0]),
      .rsvEn(rsve), .rsvReg(rsv[1:0]),
      .busyVec(o0_bv), .wrConflict(o0_cf)
   );

   regfile_bypass_sb #(.BYPASS_EN(1'b0)) u1 (
      .clk(clk), .reset_n(rst_n),
      .readReg1(rr1[1:0]), .readReg2(rr2[1:0]),
      .readData1(o1_rd1), .readData2(o1_rd2),
      .readBusy1(o1_b1), .readBusy2(o1_b2),
      .wrEnA(wea), .wrRegA(wra[1:0]), .wrDataA(wda[15:0]),
      .wrEnB(web), .wrRegB(wrb[1:0]), .wrDataB(wdb[15:0]),
      .rsvEn(rsve), .rsvReg(rsv[1:0]),
      .busyVec(o1_bv), .wrConflict(o1_cf)
   );

   regfile_bypass_sb #(.WORD_SIZE(32), .ADDR_W(3), .ZERO_REG(1'b1)) u2 (
      .clk(clk), .reset_n(rst_n),
      .readReg1(rr1), .readReg2(rr2),
      .readData1(o2_rd1), .readData2(o2_rd2),
      .readBusy1(o2_b1), .readBusy2(o2_b2),
      .wrEnA(wea), .wrRegA(wra), .wrDataA(wda),
      .wrEnB(web), .wrRegB(wrb), .wrDataB(wdb),
      .rsvEn(rsve), .rsvReg(rsv),
      .busyVec(o2_bv), .wrConflict(o2_cf)
   );

   typedef enum int {
      S0_RD1, S0_RD2, S0_BUSY1, S0_BUSY2, S0_BVEC, S0_CONF,
      S1_RD1, S2_RD1, S2_BUSY1, S2_BVEC
   } sel_e;

   typedef struct {
      string       name;
      sel_e        sel;
      logic [31:0] exp;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   task automatic push(input string n, input sel_e s, input logic [31:0] v);
      exp_t e;
      e.name = n;
      e.sel  = s;
      e.exp  = v;
      q.push_back(e);
   endtask

   function automatic logic [31:0] obs(input sel_e s);
      case (s)
         S0_RD1:   return {16'h0, o0_rd1};
         S0_RD2:   return {16'h0, o0_rd2};
         S0_BUSY1: return {31'h0, o0_b1};
         S0_BUSY2: return {31'h0, o0_b2};
         S0_BVEC:  return {28'h0, o0_bv};
         S0_CONF:  return {31'h0, o0_cf};
         S1_RD1:   return {16'h0, o1_rd1};
         S2_RD1:   return o2_rd1;
         S2_BUSY1: return {31'h0, o2_b1};
         S2_BVEC:  return {24'h0, o2_bv};
         default:  return '0;
      endcase
   endfunction

   // Monitor: at every negedge drain the queue against live DUT outputs
   initial begin
      exp_t        e;
      logic [31:0] got;
      forever begin
         @(negedge clk);
         while (q.size() > 0) begin
            e   = q.pop_front();
            got = obs(e.sel);
            checks++;
            if (got !== e.exp) begin
               errors++;
               $display("FAIL %s: got=%h want=%h", e.name, got, e.exp);
            end
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
      wea  = 1'b0;
      web  = 1'b0;
      rsve = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      rr1 = '0; rr2 = '0; wra = '0; wrb = '0; rsv = '0;
      wda = '0; wdb = '0; wea = 1'b0; web = 1'b0; rsve = 1'b0;

      // reset state, bypass suppressed during reset
      step();
      wea = 1'b1; wra = 3'd1; wda = 32'h5A5A; rr1 = 3'd1;
      push("rst_rd1", S0_RD1, 32'h0);
      push("rst_bvec", S0_BVEC, 32'h0);
      push("rst_conf", S0_CONF, 32'h0);
      step();
      rst_n = 1'b1;

      // dual write same address R0
      step();
      wea = 1'b1; wra = 3'd0; wda = 32'h1111;
      web = 1'b1; wrb = 3'd0; wdb = 32'h2222; rr1 = 3'd0;
      push("same_byp", S0_RD1, 32'h1111);
      push("same_conf_pre", S0_CONF, 32'h0);
      push("nobyp_r0_pre", S1_RD1, 32'h0);
      push("zr_r0_byp", S2_RD1, 32'h0);
      step();
      push("same_r0", S0_RD1, 32'h1111);
      push("same_conf", S0_CONF, 32'h1);
      push("nobyp_r0", S1_RD1, 32'h1111);
      push("zr_r0", S2_RD1, 32'h0);

      // dual write different addresses
      step();
      wea = 1'b1; wra = 3'd1; wda = 32'h00AA;
      web = 1'b1; wrb = 3'd2; wdb = 32'h00BB; rr1 = 3'd1; rr2 = 3'd2;
      push("conf_clear", S0_CONF, 32'h0);
      push("diff_byp1", S0_RD1, 32'h00AA);
      push("diff_byp2", S0_RD2, 32'h00BB);
      step();
      push("diff_r1", S0_RD1, 32'h00AA);
      push("diff_r2", S0_RD2, 32'h00BB);
      push("diff_conf", S0_CONF, 32'h0);
      push("nobyp_r1", S1_RD1, 32'h00AA);

      // bypass vs no bypass on R3
      wea = 1'b1; wra = 3'd3; wda = 32'h0033;
      step();
      wea = 1'b1; wra = 3'd3; wda = 32'hBEEF; rr1 = 3'd3;
      push("byp_r3", S0_RD1, 32'hBEEF);
      push("nobyp_old", S1_RD1, 32'h0033);
      push("wide_byp_r3", S2_RD1, 32'hBEEF);
      step();
      rr1 = 3'd3;
      push("byp_r3_after", S0_RD1, 32'hBEEF);
      push("nobyp_new", S1_RD1, 32'hBEEF);

      // scoreboard lifecycle on R2
      step();
      rsve = 1'b1; rsv = 3'd2; rr2 = 3'd2; rr1 = 3'd1;
      push("rsv_pre_bvec", S0_BVEC, 32'h0);
      push("rsv_pre_busy2", S0_BUSY2, 32'h0);
      step();
      push("idle1_bvec", S0_BVEC, 32'h4);
      push("idle1_busy2", S0_BUSY2, 32'h1);
      step();
      push("idle2_bvec", S0_BVEC, 32'h4);
      step();
      web = 1'b1; wrb = 3'd2; wdb = 32'h5555; rsve = 1'b1; rsv = 3'd1;
      push("wr_bvec", S0_BVEC, 32'h4);
      push("wr_busy2", S0_BUSY2, 32'h1);
      push("wr_byp_b", S0_RD2, 32'h5555);
      step();
      rsve = 1'b1; rsv = 3'd3; wea = 1'b1; wra = 3'd3; wda = 32'h3333;
      push("post_bvec", S0_BVEC, 32'h2);
      push("post_busy2", S0_BUSY2, 32'h0);
      push("post_busy1", S0_BUSY1, 32'h1);
      push("post_r2", S0_RD2, 32'h5555);
      step();
      web = 1'b1; wrb = 3'd1; wdb = 32'h0101;
      push("rsv_wr_same", S0_BVEC, 32'hA);
      step();
      rsve = 1'b1; rsv = 3'd3;
      push("rel_r1", S0_BVEC, 32'h8);
      step();
      wea = 1'b1; wra = 3'd3; wda = 32'h4444;
      push("rsv_twice", S0_BVEC, 32'h8);
      step();
      push("no_count", S0_BVEC, 32'h0);

      // zero register on u2 versus plain R0 on u0
      wea = 1'b1; wra = 3'd0; wda = 32'hFFFF_FFFF;
      rsve = 1'b1; rsv = 3'd0; rr1 = 3'd0;
      push("zr_wr_byp", S2_RD1, 32'h0);
      step();
      push("zr_rd", S2_RD1, 32'h0);
      push("zr_bvec", S2_BVEC, 32'h0);
      push("zr_busy1", S2_BUSY1, 32'h0);
      push("r0_plain_rd", S0_RD1, 32'hFFFF);
      push("r0_plain_bvec", S0_BVEC, 32'h1);

      // 32-bit, 8-entry instance: R7
      step();
      wea = 1'b1; wra = 3'd7; wda = 32'hDEAD_BEEF; rr1 = 3'd7;
      push("r7_byp", S2_RD1, 32'hDEAD_BEEF);
      step();
      rr1 = 3'd7;
      push("r7_rd", S2_RD1, 32'hDEAD_BEEF);

      // reset mid-run with pending reservation and conflict
      step();
      wea = 1'b1; wra = 3'd1; wda = 32'h1234; rsve = 1'b1; rsv = 3'd2;
      step();
      wea = 1'b1; wra = 3'd3; wda = 32'h0A0A;
      web = 1'b1; wrb = 3'd3; wdb = 32'h0B0B; rr1 = 3'd1;
      push("pre_rst_r1", S0_RD1, 32'h1234);
      push("pre_rst_bvec", S0_BVEC, 32'h5);
      step();
      wea = 1'b1; wra = 3'd1; wda = 32'h7777; rr1 = 3'd1;
      rst_n = 1'b0;
      push("mid_rst_rd1", S0_RD1, 32'h0);
      push("mid_rst_bvec", S0_BVEC, 32'h0);
      push("mid_rst_conf", S0_CONF, 32'h0);
      push("mid_rst_busy1", S0_BUSY1, 32'h0);
      @(negedge clk);
      #1;
      wea = 1'b0; web = 1'b0; rsve = 1'b0;
      rst_n = 1'b1;
      step();
      rr1 = 3'd1;
      push("post_rst_rd1", S0_RD1, 32'h0);
      push("post_rst_bvec", S0_BVEC, 32'h0);
      push("post_rst_wbvec", S2_BVEC, 32'h0);
      push("post_rst_conf", S0_CONF, 32'h0);

      @(negedge clk);
      #1;
      checks++;
      if (q.size() != 0) begin
         errors++;
         $display("FAIL queue_drain: got=%0d pending want=0", q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
